// File: rtl/nibble_serial_add_seq_if.sv
// Operand request and result handshake bundle for nibble_serial_add_seq.
// The requester holds the master modport; the sequencer holds the slave modport.
interface nibble_serial_add_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Streams two W-bit operands LSB nibble first through an external 4-bit adder slice,
// registering the carry between slices; subtract is A + ~B + 1.
module nibble_serial_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_add_seq_if.slave bus,
  output logic [3:0]            nib_a,
  output logic [3:0]            nib_b,
  output logic                  nib_cin,
  input  logic [3:0]            nib_s,
  input  logic                  nib_cout,
  output logic                  busy
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q, out_valid_q;
  logic              last;
  logic [IdxW+1:0]   bit_base;

  assign last     = (idx_q == IdxW'(NIBBLES - 1));
  assign bit_base = {idx_q, 2'b00};

  assign bus.in_ready  = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    nib_a   = 4'h0;
    nib_b   = 4'h0;
    nib_cin = 1'b0;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StRun;
      StRun: begin
        nib_a   = a_q[bit_base +: 4];
        nib_b   = b_q[bit_base +: 4];
        nib_cin = carry_q;
        if (last) state_d = StDone;
      end
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.op_sub | bus.op_cin;
            idx_q   <= '0;
          end
        end
        StRun: begin
          sum_q[bit_base +: 4] <= nib_s;
          carry_q              <= nib_cout;
          if (last) begin
            // Result flags are frozen here so a new accept cannot disturb them.
            cout_q      <= nib_cout;
            ovf_q       <= (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_add_seq.md
# nibble_serial_add_seq

Multi-cycle sequencer that adds or subtracts two `4*NIBBLES`-bit operands by streaming them, least-significant nibble first, through an external 4-bit adder slice. The carry is registered between slices. It sits directly upstream and downstream of the team's 4-bit carry-select adder. It drives the adder's A/B/carry-in and consumes its sum and carry-out in the same cycle. Operand and result transfers use valid/ready handshakes.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: high only in IDLE.
- `op_a` in W: operand A.
- `op_b` in W: operand B.
- `op_cin` in 1: carry-in for add; ignored for subtract.
- `op_sub` in 1: 1 = A − B, computed as A + ~B + 1.
- `nib_a` out 4: adder slice A.
- `nib_b` out 4: adder slice B, already inverted when subtracting.
- `nib_cin` out 1: adder slice carry-in.
- `nib_s` in 4: adder slice sum; combinational return, sampled the same cycle.
- `nib_cout` in 1: adder slice carry-out.
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumed.
- `sum` out W: result.
- `cout` out 1: final carry; for subtract, 1 = no borrow.
- `ovf` out 1: two's-complement overflow.
- `busy` out 1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. A nibble index `idx` counts 0..NIBBLES−1.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, at that edge: latch `a_reg`=`op_a` and `b_reg`=`op_sub ? ~op_b : op_b`.
  - Set carry=`op_sub ? 1 : op_cin`, `idx`=0, and latch `sub_reg`. Go to RUN.
- **RUN**
  - Combinational outputs: `nib_a`=`a_reg[4*idx+:4]`, `nib_b`=`b_reg[4*idx+:4]`, `nib_cin`=carry.
  - Each edge: `sum[4*idx+:4]`←`nib_s`, carry←`nib_cout`, `idx`++.
  - At the edge where `idx`=NIBBLES−1, go to DONE instead of incrementing.
- **DONE**
  - `out_valid`=1.
  - `cout` = the registered final carry.
  - `ovf` = (`a_reg` MSB == `b_reg` MSB) && (`sum` MSB != `a_reg` MSB), using the possibly inverted `b_reg`.
  - On `out_valid && out_ready`, go to IDLE.
- Outside RUN, `nib_a`, `nib_b` and `nib_cin` are 0.
- `sum`, `cout` and `ovf` stay stable from DONE entry until the next operation's first RUN write.
- `in_valid` is ignored while not in IDLE; no capture, no error.
- `rst` asserted in any state, including mid-RUN:
  - The operation is aborted immediately.
  - State goes to IDLE; all registers and `sum`, `cout`, `ovf`, `out_valid`, `busy` go to 0.
  - `in_ready` is 1 while in reset; `in_valid` is not captured until the first edge after `rst` deasserts.

## Timing
- Accept edge E0 (`in_valid && in_ready`).
- RUN occupies the NIBBLES cycles after E0; nibble k is written at edge E0+k+1.
- `out_valid` rises after edge E0+NIBBLES. For NIBBLES=4, that is the 5th cycle after the accept cycle.
- DONE is held for any number of cycles under `out_ready`=0.
- Handshake edge Ed → IDLE; `in_ready`=1 in the cycle after Ed.
- No same-cycle result→operand bypass. Minimum throughput is one operation per NIBBLES+2 cycles.
- Outputs are registered except `in_ready`, `busy` and `nib_*`, which decode from state/`idx`.

## Test plan
- **Add with carry propagation.** NIBBLES=4, 0x1234+0x0FFF, cin=0 → `sum`=0x2233, `cout`=0, `ovf`=0.
  - Slice trace `nib_a`=4,3,2,1; `nib_b`=F,F,F,0; `nib_cin`=0,1,1,1.
  - `out_valid` asserted 4 edges after E0.
- **Full wrap.** 0xFFFF+0x0001, cin=1 → `sum`=0x0001, `cout`=1, `ovf`=0.
- **Subtract.**
  - 0x0005−0x0007 → `sum`=0xFFFE, `cout`=0, `ovf`=0.
  - 0x8000−0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
- **Signed add overflow.** 0x7FFF+0x0001, cin=0 → `sum`=0x8000, `ovf`=1, `cout`=0.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles in DONE while pulsing `in_valid` with new operands.
  - `sum`, `cout`, `ovf` and `out_valid` stay stable; `in_ready`=0; no capture occurs.
  - After release, `in_ready`=1 one cycle after the handshake edge.
- **Reset mid-RUN.** Assert `rst` asynchronously during RUN (`idx`=2).
  - Immediately: `out_valid`=0, `sum`=0, `busy`=0, `in_ready`=1.
  - After deassertion, 0x00FF+0x0001 → `sum`=0x0100, `cout`=0.
